// File: rtl/cmp_pkg.sv
// Shared types and helpers for the chunked iterative comparator.
// The FSM states, result bundle and chunk-count helper live here so they stay consistent across files.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic neq;
    logic grt;
    logic lss;
  } result_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational magnitude compare of one CHUNK-bit slice.
// msb_flip inverts the top bit so that the most significant slice orders two's-complement values.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_flip,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_adj;
  logic [CHUNK-1:0] b_adj;

  assign flip  = msb_flip ? (CHUNK'(1) << (CHUNK - 1)) : '0;
  assign a_adj = a ^ flip;
  assign b_adj = b ^ flip;
  assign gt    = a_adj > b_adj;
  assign lt    = a_adj < b_adj;

endmodule

// File: rtl/cmp_iter.sv
// Iterative comparator: scans operands one chunk per cycle from the MSB end and stops
// at the first differing chunk; the result is held until the consumer takes it.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             neq,
  output logic             grt,
  output logic             lss
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("cmp_iter: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_reg, state_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             sign_reg, sign_next;
  logic [WIDTH-1:0] op1_reg, op1_next;
  logic [WIDTH-1:0] op2_reg, op2_next;
  result_t          res_reg, res_next;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             msb_flip;
  logic             chunk_gt;
  logic             chunk_lt;

  genvar gi;
  for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_chunks[gi] = op1_reg[gi*CHUNK +: CHUNK];
    assign b_chunks[gi] = op2_reg[gi*CHUNK +: CHUNK];
  end

  assign chunk_a  = a_chunks[idx_reg];
  assign chunk_b  = b_chunks[idx_reg];
  // Only the top slice carries the sign bit.
  assign msb_flip = sign_reg && (idx_reg == IW'(NCHUNK - 1));

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (chunk_a),
    .b        (chunk_b),
    .msb_flip (msb_flip),
    .gt       (chunk_gt),
    .lt       (chunk_lt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sign_reg  <= 1'b0;
      op1_reg   <= '0;
      op2_reg   <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      sign_reg  <= sign_next;
      op1_reg   <= op1_next;
      op2_reg   <= op2_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    sign_next  = sign_reg;
    op1_next   = op1_reg;
    op2_next   = op2_reg;
    res_next   = res_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = sign;
          op1_next   = op1;
          op2_next   = op2;
          idx_next   = IW'(NCHUNK - 1);
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (chunk_gt || chunk_lt) begin
          res_next   = '{eq: 1'b0, neq: 1'b1, grt: chunk_gt, lss: chunk_lt};
          state_next = DONE;
        end else if (idx_reg == '0) begin
          res_next   = '{eq: 1'b1, neq: 1'b0, grt: 1'b0, lss: 1'b0};
          state_next = DONE;
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign eq        = res_reg.eq;
  assign neq       = res_reg.neq;
  assign grt       = res_reg.grt;
  assign lss       = res_reg.lss;

endmodule

// File: tb/tb_cmp_iter.sv
// Randomised bench for cmp_iter (WIDTH=32, CHUNK=8) against an arithmetic reference model,
// plus directed cases with literal expectations, output hold and mid-scan reset.
module tb_cmp_iter;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             sign = 1'b0;
  logic [WIDTH-1:0] op1 = '0;
  logic [WIDTH-1:0] op2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             eq, neq, grt, lss;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_res;      // {eq, neq, grt, lss}
  int         exp_k;
  bit         exp_active = 1'b0;

  always #5 clk = ~clk;

  cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .neq       (neq),
    .grt       (grt),
    .lss       (lss)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] model_res(input logic s, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    bit gt;
    if (a == b) return 4'b1000;
    gt = s ? ($signed(a) > $signed(b)) : (a > b);
    return {1'b0, 1'b1, gt, !gt};
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = NCH - 1; i >= 0; i--)
      if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) return NCH - i;
    return NCH;
  endfunction

  // Result must match the model on every cycle a result is presented.
  always @(negedge clk) begin
    if (resetn && exp_active && out_valid) begin
      check("result", {28'd0, eq, neq, grt, lss}, {28'd0, exp_res});
      check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic run_txn(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold, input bit use_lit, input logic [3:0] lit_res,
                         input int lit_k);
    int cnt;
    exp_res = model_res(s, a, b);
    exp_k   = model_lat(a, b);
    if (use_lit) begin
      check("model_res_lit", {28'd0, exp_res}, {28'd0, lit_res});
      check("model_lat_lit", exp_k, lit_k);
    end
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    sign = s; op1 = a; op2 = b; in_valid = 1'b1;
    exp_active = 1'b1;
    @(posedge clk); #1;
    // Disturb inputs while busy; the captured operands must be used.
    in_valid = 1'($urandom); op1 = $urandom; op2 = $urandom; sign = 1'($urandom);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 20);
    check("latency", cnt, exp_k);
    if (use_lit) check("latency_lit", cnt, lit_k);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      if (use_lit) check("hold_res_lit", {28'd0, eq, neq, grt, lss}, {28'd0, lit_res});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_after_take", {31'd0, out_valid}, 32'd0);
    check("ready_after_take", {31'd0, in_ready}, 32'd1);
    exp_active = 1'b0;
    out_ready = 1'b0;
    $display("txn sign=%0d op1=%08h op2=%08h res=%04b lat=%0d", s, a, b, exp_res, exp_k);
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {28'd0, eq, neq, grt, lss}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run_txn(1'b0, 32'h12345678, 32'h12345678, 0, 1'b1, 4'b1000, 4);
    run_txn(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 1'b1, 4'b0110, 1);
    run_txn(1'b1, 32'hFFFFFFFF, 32'h00000001, 0, 1'b1, 4'b0101, 1);
    run_txn(1'b1, 32'h80000000, 32'h7FFFFFFF, 0, 1'b1, 4'b0101, 1);
    run_txn(1'b1, 32'h000000FF, 32'h000000FE, 10, 1'b1, 4'b0110, 4);
    run_txn(1'b0, 32'h80000000, 32'h7FFFFFFF, 2, 1'b1, 4'b0110, 1);
    run_txn(1'b1, 32'h12AB0000, 32'h12340000, 0, 1'b1, 4'b0110, 2);

    // Reset two edges into a full-length scan aborts it.
    @(negedge clk);
    sign = 1'b0; op1 = 32'hCAFEBABE; op2 = 32'hCAFEBABE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_result", {28'd0, eq, neq, grt, lss}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_txn(1'b1, 32'h00000001, 32'hFFFFFFFF, 0, 1'b1, 4'b0110, 1);

    for (int t = 0; t < 200; t++) begin
      a = $urandom;
      b = a;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 2) == 0) b[c*CHUNK +: CHUNK] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b[WIDTH-1] = ~b[WIDTH-1];
      run_txn(1'($urandom), a, b, $urandom_range(0, 3), 1'b0, 4'b0000, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/cmp_iter.md
CMP_ITER -- requirements
Module: cmp_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH % CHUNK == 0 is required, else elaboration error.
REQ-003 SHALL define NCHUNK = WIDTH/CHUNK as a localparam.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operands presented.
REQ-007 SHALL have port in_ready, output, 1, block can accept operands.
REQ-008 SHALL have port sign, input, 1, 1 = two's-complement compare, 0 = unsigned.
REQ-009 SHALL have port op1, input, WIDTH, first operand.
REQ-010 SHALL have port op2, input, WIDTH, second operand.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, consumer takes result.
REQ-013 SHALL have ports eq, neq, grt, lss, output, 1 each, op1==op2, op1!=op2, op1>op2, op1<op2.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE.
REQ-016 SHALL capture sign, op1 and op2 and enter SCAN on a clock edge where in_valid && in_ready; chunk index = NCHUNK-1 (MSB chunk).
REQ-017 SHALL compare one chunk per cycle in SCAN, MSB-first, and decrement the index.
REQ-018 SHALL, when sign=1, invert bit WIDTH-1 of both captured operands for the MSB-chunk compare only.
REQ-019 SHALL, on the first differing chunk, latch grt/lss from that chunk, set neq=1 and eq=0, and go to DONE (early termination).
REQ-020 SHALL, when chunk index 0 compares equal, latch eq=1, neq=grt=lss=0 and go to DONE.
REQ-021 SHALL give latency from accept edge to out_valid=1 of k edges, where k = (NCHUNK - index of first differing chunk); k = NCHUNK if the operands are equal; minimum 1, maximum NCHUNK.
REQ-022 SHALL assert out_valid = 1 only in DONE; eq/neq/grt/lss are registered and stable while out_valid=1.
REQ-023 SHALL go DONE -> IDLE on an edge where out_ready=1; with out_ready=0, DONE is held indefinitely and outputs are unchanged.
REQ-024 SHALL keep exactly one of eq, neq high when out_valid=1; grt and lss are mutually exclusive; grt|lss == neq.
REQ-025 SHALL ignore in_valid and operand changes outside IDLE; the captured operands are used.
REQ-026 SHALL NOT allow back-to-back overlap: the next accept is possible at the earliest one edge after DONE is left (IDLE cycle).
REQ-027 SHALL, for NCHUNK=1, degenerate to a single SCAN cycle with latency 1.

Reset
REQ-028 SHALL, while resetn=0, immediately force state=IDLE, out_valid=0, eq=neq=grt=lss=0, chunk index=0 and captured operands=0.
REQ-029 SHALL drive in_ready=1 after reset (IDLE).
REQ-030 SHALL, on a reset asserted in SCAN or DONE, abort the operation; no result is produced for it.

Structure
REQ-031 SHALL place the FSM state enum typedef, result struct (eq, neq, grt, lss) and the NCHUNK helper function in shared package cmp_pkg.
REQ-032 SHALL instantiate sub-module cmp_chunk (combinational, parameter CHUNK; inputs a, b, msb_flip; outputs gt, lt) once.

Verification (WIDTH=32, CHUNK=8)
REQ-033 Bench SHALL drive sign=0, op1=op2=0x12345678, out_ready=1 -> eq=1, neq=grt=lss=0, out_valid 4 edges after accept.
REQ-034 Bench SHALL drive sign=0, op1=0xFFFFFFFF, op2=0x00000001 -> grt=1, neq=1 after 1 edge; with sign=1 -> lss=1 after 1 edge.
REQ-035 Bench SHALL drive sign=1, op1=0x80000000, op2=0x7FFFFFFF -> lss=1 after 1 edge; op1=0x000000FF, op2=0x000000FE -> grt=1 after 4 edges.
REQ-036 Bench SHALL hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable and in_ready=0 throughout; on out_ready=1 -> IDLE next edge and in_ready=1.
REQ-037 Bench SHALL assert resetn=0 two edges into a 4-chunk SCAN -> out_valid=0 and in_ready=1 immediately; the next transaction completes correctly.
